// File: rtl/glitcher_pkg.sv
// Shared types and constants for the glitcher: sequencer state encoding,
// default field widths and the UART command opcodes used by the decoder.
package glitcher_pkg;

    localparam int DEF_DELAY_W     = 16;
    localparam int DEF_WIDTH_W     = 8;
    localparam int DEF_COUNT_W     = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // ASCII opcodes so the link can be driven by hand from a terminal.
    localparam logic [7:0] OP_SET_DELAY = 8'h44;  // 'D'
    localparam logic [7:0] OP_SET_WIDTH = 8'h57;  // 'W'
    localparam logic [7:0] OP_SET_GAP   = 8'h47;  // 'G'
    localparam logic [7:0] OP_SET_COUNT = 8'h43;  // 'C'
    localparam logic [7:0] OP_ARM       = 8'h41;  // 'A'
    localparam logic [7:0] OP_ABORT     = 8'h58;  // 'X'
    localparam logic [7:0] OP_STATUS    = 8'h53;  // 'S'

    function automatic logic is_busy_state(input state_e s);
        return (s == ST_DELAY) || (s == ST_PULSE) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/glitch_sequencer_trigger_sync.sv
// Brings the asynchronous trigger pin into the clock domain and turns its
// rising edge into a registered one-cycle pulse.
module trigger_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_q, lvl_d;
    logic                   lvl_prev_q, lvl_prev_d;
    logic                   edge_q, edge_d;

    // The level is retimed once more after the synchroniser so the edge
    // compare never looks at a flop that may still be resolving.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], async_in};
        lvl_d      = sync_q[SYNC_STAGES-1];
        lvl_prev_d = lvl_q;
        edge_d     = lvl_q & ~lvl_prev_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
            edge_q     <= edge_d;
        end
    end

    assign edge_out = edge_q;

endmodule

// File: rtl/glitch_sequencer.sv
// Glitch pulse-train sequencer: latches delay/width/gap/count in IDLE, arms,
// waits for a trigger edge and emits the timed pulse train on glitch_out.
module glitch_sequencer
    import glitcher_pkg::*;
#(
    parameter int DELAY_W     = DEF_DELAY_W,
    parameter int WIDTH_W     = DEF_WIDTH_W,
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  logic [DELAY_W-1:0] cfg_gap,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic               cmd_arm,
    input  logic               cmd_abort,
    input  logic               trigger_in,
    output logic               glitch_out,
    output logic               armed,
    output logic               busy,
    output logic               done,
    output logic               err,
    output state_e             dbg_state
);

    // Config handshake: a word transfers on every edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is high exactly while in IDLE and
    // nothing is stalled, so the decoder may drop cfg_valid after one cycle.

    state_e state_q, state_d;

    logic [DELAY_W-1:0] cfg_delay_q, cfg_delay_d;
    logic [WIDTH_W-1:0] cfg_width_q, cfg_width_d;
    logic [DELAY_W-1:0] cfg_gap_q, cfg_gap_d;
    logic [COUNT_W-1:0] cfg_count_q, cfg_count_d;

    logic [DELAY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [WIDTH_W-1:0] width_cnt_q, width_cnt_d;
    logic [COUNT_W-1:0] rep_cnt_q, rep_cnt_d;

    logic glitch_q, glitch_d;
    logic armed_q, armed_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic cfg_ready_q, cfg_ready_d;

    logic               trig_edge;
    logic               cfg_take;
    logic [WIDTH_W-1:0] eff_width;
    logic [COUNT_W-1:0] rep_load;
    logic               dly_last;
    logic               pulse_last;
    logic               more_pulses;

    trigger_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trigger_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(trigger_in),
        .edge_out(trig_edge)
    );

    // A config written in the same cycle as the arm is the one checked.
    assign cfg_take    = cfg_valid && cfg_ready_q;
    assign eff_width   = cfg_take ? cfg_width : cfg_width_q;
    assign rep_load    = (cfg_count_q == '0) ? COUNT_W'(1) : cfg_count_q;
    assign dly_last    = (dly_cnt_q == DELAY_W'(1));
    assign pulse_last  = (width_cnt_q == WIDTH_W'(1));
    assign more_pulses = (rep_cnt_q > COUNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            glitch_q    <= 1'b0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            glitch_q    <= glitch_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_arm && (eff_width != '0)) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (trig_edge) state_d = (cfg_delay_q != '0) ? ST_DELAY : ST_PULSE;
            end
            ST_DELAY: begin
                if (dly_last) state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (pulse_last) begin
                    if (!more_pulses)          state_d = ST_IDLE;
                    else if (cfg_gap_q != '0)  state_d = ST_GAP;
                    else                       state_d = ST_PULSE;
                end
            end
            ST_GAP: begin
                if (dly_last) state_d = ST_PULSE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (cmd_abort) state_d = ST_IDLE;
    end

    // Outputs are decoded from the next state and registered, so each one
    // changes on the same edge as the state it reflects.
    always_comb begin
        glitch_d    = (state_d == ST_PULSE);
        armed_d     = (state_d == ST_ARMED);
        busy_d      = is_busy_state(state_d);
        cfg_ready_d = (state_d == ST_IDLE);
        done_d      = (state_q == ST_PULSE) && pulse_last && !more_pulses && !cmd_abort;
        err_d       = (state_q == ST_IDLE) && cmd_arm && (eff_width == '0) && !cmd_abort;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_delay_q <= '0;
            cfg_width_q <= '0;
            cfg_gap_q   <= '0;
            cfg_count_q <= '0;
            dly_cnt_q   <= '0;
            width_cnt_q <= '0;
            rep_cnt_q   <= '0;
        end else begin
            cfg_delay_q <= cfg_delay_d;
            cfg_width_q <= cfg_width_d;
            cfg_gap_q   <= cfg_gap_d;
            cfg_count_q <= cfg_count_d;
            dly_cnt_q   <= dly_cnt_d;
            width_cnt_q <= width_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    always_comb begin
        cfg_delay_d = cfg_delay_q;
        cfg_width_d = cfg_width_q;
        cfg_gap_d   = cfg_gap_q;
        cfg_count_d = cfg_count_q;
        if (cfg_take) begin
            cfg_delay_d = cfg_delay;
            cfg_width_d = cfg_width;
            cfg_gap_d   = cfg_gap;
            cfg_count_d = cfg_count;
        end
    end

    // dly_cnt serves both the initial delay and the inter-pulse gap.
    always_comb begin
        dly_cnt_d   = dly_cnt_q;
        width_cnt_d = width_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        unique case (state_q)
            ST_ARMED: begin
                if (trig_edge) begin
                    rep_cnt_d   = rep_load;
                    dly_cnt_d   = cfg_delay_q;
                    width_cnt_d = cfg_width_q;
                end
            end
            ST_DELAY, ST_GAP: begin
                dly_cnt_d = dly_cnt_q - DELAY_W'(1);
                if (dly_last) width_cnt_d = cfg_width_q;
            end
            ST_PULSE: begin
                width_cnt_d = width_cnt_q - WIDTH_W'(1);
                if (pulse_last) begin
                    rep_cnt_d   = rep_cnt_q - COUNT_W'(1);
                    dly_cnt_d   = cfg_gap_q;
                    width_cnt_d = cfg_width_q;
                end
            end
            default: ;
        endcase
    end

    assign glitch_out = glitch_q;
    assign armed      = armed_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cfg_ready  = cfg_ready_q;
    assign dbg_state  = state_q;

endmodule
